// File: rtl/apb_completer_regfile.sv
// apb_completer_regfile
//   APB completer register bank. Word-aligned register decode relative to
//   BASE_ADDR, fixed wait states, byte-strobed writes. The last register word
//   is a read-only saturating count of transfers completed without error.
//   pslverr flags out-of-range addresses, writes to the counter and, when
//   SECURE_ONLY=1, non-secure (pprot[1]=1) accesses.
// Ports
//   pclk, preset          clock, synchronous active-high reset
//   paddr/pprot/pnse      address and protection (pnse accepted, unused)
//   psel/penable/pwrite   APB control
//   pwdata/pstrb          write data and byte strobes
//   pready/prdata/pslverr response (prdata/pslverr zero unless pready)
//   pwakeup               accepted, unused
//   protocol_err          sticky APB sequencing violation flag
module apb_completer_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 2,
  parameter int                    SECURE_ONLY = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    pnse,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  input  logic                    pwakeup,
  output logic                    protocol_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LG = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(NUM_REGS * NB);
  localparam logic [ADDR_WIDTH-1:0] CTR_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                               state_q, state_d;
  logic [3:0]                           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic                                 wr_q, wr_d;
  logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
  logic [NB-1:0]                        strb_q, strb_d;
  logic                                 nsec_q, nsec_d;
  logic [NUM_REGS-2:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [DATA_WIDTH-1:0]                ctr_q, ctr_d;
  logic                                 perr_q, perr_d;

  logic [ADDR_WIDTH-1:0] off, idx;
  logic                  err, active, done;
  logic [DATA_WIDTH-1:0] rdata;

  // Pins that carry no behaviour in this block.
  logic unused_ok;
  assign unused_ok = ^{pnse, pwakeup, pprot[2], pprot[0]};

  // Decode works purely from the latched setup-phase attributes.
  always_comb begin
    off = addr_q - BASE_ADDR;  // wraps, so addresses below base land out of range
    idx = off >> LG;
    err = (off >= SPAN) || ((SECURE_ONLY != 0) && nsec_q) || (wr_q && (idx == CTR_IDX));
    rdata = '0;
    if (idx == CTR_IDX) rdata = ctr_q;
    for (int i = 0; i < NUM_REGS - 1; i++)
      if (idx == ADDR_WIDTH'(i)) rdata = regs_q[i];
  end

  assign active       = (state_q == ACCESS) && psel && penable;
  // Reset forces the response quiet in the very cycle it is asserted.
  assign done         = active && (cnt_q == 4'd0) && !preset;
  assign pready       = done;
  assign pslverr      = done && err;
  assign prdata       = (done && !err && !wr_q) ? rdata : '0;
  assign protocol_err = perr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    nsec_d  = nsec_q;
    regs_d  = regs_q;
    ctr_d   = ctr_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (penable) begin
          perr_d = 1'b1;
        end else if (psel) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          nsec_d  = pprot[1];
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!(psel && penable)) begin
          // Aborted transfer: nothing is committed.
          perr_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          if (!err) begin
            if (wr_q)
              for (int i = 0; i < NUM_REGS - 1; i++)
                if (idx == ADDR_WIDTH'(i))
                  for (int b = 0; b < NB; b++)
                    if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
            if (ctr_q != '1) ctr_d = ctr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      nsec_q  <= 1'b0;
      regs_q  <= '0;
      ctr_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      nsec_q  <= nsec_d;
      regs_q  <= regs_d;
      ctr_q   <= ctr_d;
      perr_q  <= perr_d;
    end
  end
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile. Two instances:
//   u0: BASE 0x40, 16 regs, 2 wait states, secure checks off (counter at 0x7C)
//   u1: BASE 0x100, 4 regs, no wait states, SECURE_ONLY=1 (counter at 0x10C)
// Stimulus pushes expected responses to a per-instance queue; a negedge
// monitor pops and compares whenever pready is seen.
module tb_apb_completer_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset;
  logic [1:0]  psel, penable, pwrite, pready, pslverr, perr, pnse, pwakeup;
  logic [31:0] paddr[2], pwdata[2], prdata[2];
  logic [3:0]  pstrb[2];
  logic [2:0]  pprot[2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc[2];

  apb_completer_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h40),
                          .WAIT_CYCLES(2), .SECURE_ONLY(0)) u0 (
    .pclk(clk), .preset(preset), .paddr(paddr[0]), .pprot(pprot[0]), .pnse(pnse[0]),
    .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
    .pstrb(pstrb[0]), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]),
    .pwakeup(pwakeup[0]), .protocol_err(perr[0]));

  apb_completer_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h100),
                          .WAIT_CYCLES(0), .SECURE_ONLY(1)) u1 (
    .pclk(clk), .preset(preset), .paddr(paddr[1]), .pprot(pprot[1]), .pnse(pnse[1]),
    .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
    .pstrb(pstrb[1]), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]),
    .pwakeup(pwakeup[1]), .protocol_err(perr[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: latency counts access cycles up to and including the pready cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (psel[d] && penable[d]) begin
        if (pready[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_pready%0d", d), {31'b0, pready[d]}, 32'd0);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("prdata%0d", d), prdata[d], e.rdata);
            chk($sformatf("pslverr%0d", d), {31'b0, pslverr[d]}, {31'b0, e.err});
            chk($sformatf("latency%0d", d), acc[d] + 1, e.lat);
          end
          acc[d] = 0;
        end else begin
          acc[d]++;
        end
      end else begin
        acc[d] = 0;
      end
    end
  end

  // One APB transfer; with last=0 the bus stays in access so the next call
  // issues its setup immediately after completion (back-to-back).
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input logic [31:0] erd,
                      input logic eer, input logic last);
    exp_t x;
    x.rdata = erd;
    x.err   = eer;
    x.lat   = (d == 0) ? 3 : 1;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = w;
    pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pready[d]) break;
    end
    if (!pready[d]) chk($sformatf("timeout%0d", d), {31'b0, pready[d]}, 32'd1);
    if (last) begin
      @(posedge clk); #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
    end
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd,
                    input logic [3:0] st, input logic [2:0] pr, input logic eer);
    xfer(d, a, 1'b1, wd, st, pr, 32'h0, eer, 1'b1);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [2:0] pr,
                    input logic [31:0] erd, input logic eer);
    xfer(d, a, 1'b0, 32'h0, 4'hF, pr, erd, eer, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1;
    psel = '0; penable = '0; pwrite = '0; pnse = '0; pwakeup = '0;
    acc[0] = 0; acc[1] = 0;
    for (int d = 0; d < 2; d++) begin
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", {30'b0, pready}, 32'd0);
    chk("rst_pslverr", {30'b0, pslverr}, 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    chk("rst_perr", {30'b0, perr}, 32'd0);
    @(posedge clk); #1 preset = 1'b0;

    // Full write, readback (good transfers: 2)
    wr(0, 32'h44, 32'hA5A5_1234, 4'hF, 3'b000, 1'b0);
    rd(0, 32'h44, 3'b000, 32'hA5A5_1234, 1'b0);
    // Byte strobes, zero strobe, ignored byte offset (good: 8)
    wr(0, 32'h44, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0);
    wr(0, 32'h44, 32'h0000_0000, 4'b0101, 3'b000, 1'b0);
    rd(0, 32'h44, 3'b000, 32'hFF00_FF00, 1'b0);
    wr(0, 32'h44, 32'h1234_5678, 4'b0000, 3'b000, 1'b0);
    rd(0, 32'h44, 3'b000, 32'hFF00_FF00, 1'b0);
    rd(0, 32'h47, 3'b000, 32'hFF00_FF00, 1'b0);
    // Errors: past the top, counter write, below base; counter is pre-increment
    rd(0, 32'h80, 3'b000, 32'h0, 1'b1);
    wr(0, 32'h7C, 32'h0000_0001, 4'hF, 3'b000, 1'b1);
    rd(0, 32'h7C, 3'b000, 32'd8, 1'b0);
    rd(0, 32'h7C, 3'b000, 32'd9, 1'b0);
    rd(0, 32'h3C, 3'b000, 32'h0, 1'b1);
    rd(0, 32'h48, 3'b000, 32'h0, 1'b0);                     // good: 11
    // Back-to-back transfers (good: 15)
    xfer(0, 32'h48, 1'b1, 32'h1111_2222, 4'hF, 3'b000, 32'h0, 1'b0, 1'b0);
    xfer(0, 32'h4C, 1'b1, 32'h3333_4444, 4'hF, 3'b000, 32'h0, 1'b0, 1'b0);
    xfer(0, 32'h48, 1'b0, 32'h0, 4'hF, 3'b000, 32'h1111_2222, 1'b0, 1'b0);
    xfer(0, 32'h4C, 1'b0, 32'h0, 4'hF, 3'b000, 32'h3333_4444, 1'b0, 1'b1);

    // Abort by dropping psel during the wait states
    chk("perr0_pre", {31'b0, perr[0]}, 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h50; pwrite[0] = 1'b1;
    pwdata[0] = 32'hDEAD_BEEF; pstrb[0] = 4'hF; pprot[0] = 3'b000;
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk); #1 begin psel[0] = 1'b0; penable[0] = 1'b0; end
    @(posedge clk);
    @(negedge clk);
    chk("perr0_abort", {31'b0, perr[0]}, 32'd1);
    rd(0, 32'h7C, 3'b000, 32'd15, 1'b0);
    rd(0, 32'h50, 3'b000, 32'h0, 1'b0);

    // Secure-only instance, zero wait states
    wr(1, 32'h104, 32'hCAFE_F00D, 4'hF, 3'b010, 1'b1);
    rd(1, 32'h104, 3'b000, 32'h0, 1'b0);
    wr(1, 32'h104, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b0);
    rd(1, 32'h104, 3'b000, 32'hCAFE_F00D, 1'b0);
    rd(1, 32'h104, 3'b010, 32'h0, 1'b1);
    rd(1, 32'h10C, 3'b000, 32'd3, 1'b0);
    rd(1, 32'h10C, 3'b000, 32'd4, 1'b0);
    wr(1, 32'h10C, 32'h0, 4'hF, 3'b000, 1'b1);
    rd(1, 32'h110, 3'b000, 32'h0, 1'b1);

    // penable without psel while idle
    chk("perr1_pre", {31'b0, perr[1]}, 32'd0);
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 penable[1] = 1'b0;
    @(negedge clk);
    chk("perr1_idle_penable", {31'b0, perr[1]}, 32'd1);

    // Reset arriving in the cycle the write would complete
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h44; pwrite[0] = 1'b1;
    pwdata[0] = 32'h1111_1111; pstrb[0] = 4'hF; pprot[0] = 3'b000;
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 preset = 1'b1;
    @(negedge clk);
    chk("pready_in_reset", {31'b0, pready[0]}, 32'd0);
    @(posedge clk); #1 begin preset = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0; end
    @(negedge clk);
    chk("pready_after_reset", {31'b0, pready[0]}, 32'd0);
    chk("perr_after_reset", {30'b0, perr}, 32'd0);
    rd(0, 32'h7C, 3'b000, 32'd0, 1'b0);
    rd(0, 32'h44, 3'b000, 32'h0, 1'b0);
    rd(0, 32'h48, 3'b000, 32'h0, 1'b0);
    rd(1, 32'h104, 3'b000, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_empty0", q0.size(), 32'd0);
    chk("sb_empty1", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
